// File: rtl/audio_pkg.sv
// Shared definitions for the PDM microphone capture path.
//   DECIM_DEFAULT / PCM_W_DEFAULT : default decimation window and PCM width
//   clog2                         : ceiling log2, usable in constant expressions
//   state_t                       : capture FSM encoding (ST_IDLE, ST_ACCUM)
package audio_pkg;

    localparam int DECIM_DEFAULT = 128;
    localparam int PCM_W_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Smallest r such that 2**r >= value.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pdm_mic_capture_if.sv
// PCM sample stream between the PDM capture block and the audio path.
//   pcm_data  : unsigned PCM sample
//   pcm_valid : pcm_data holds an unconsumed sample
//   pcm_ready : sink accepts the sample when pcm_valid && pcm_ready
// master = sample producer, slave = sample consumer.
interface pdm_mic_capture_if
    import audio_pkg::*;
#(
    parameter int PCM_W = PCM_W_DEFAULT
) ();

    logic [PCM_W-1:0] pcm_data;
    logic             pcm_valid;
    logic             pcm_ready;

    modport master (
        output pcm_data,
        output pcm_valid,
        input  pcm_ready
    );

    modport slave (
        input  pcm_data,
        input  pcm_valid,
        output pcm_ready
    );

endinterface

// File: rtl/pdm_edge_sync.sv
// Dual-chain synchroniser plus rising-edge detector for a PDM mic link.
// mic_clk is handled as data: both pins go through identical flop chains so
// their relative timing is preserved, then mic_clk is edge-detected.
//   clk, reset : system clock, synchronous active-high reset
//   mic_clk    : mic clock pin (asynchronous to clk)
//   mic_data   : PDM data pin (asynchronous to clk)
//   edge_pulse : one-cycle pulse on each synchronised mic_clk rise
//   data_bit   : synchronised data, valid as the PDM bit when edge_pulse=1
module pdm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic mic_clk,
    input  logic mic_data,
    output logic edge_pulse,
    output logic data_bit
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_sync_d;

    // Synchroniser chains: bit 0 faces the pins, MSB is the safe output.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync   <= '0;
            data_sync  <= '0;
            clk_sync_d <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], mic_clk};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], mic_data};
            clk_sync_d <= clk_sync[SYNC_STAGES-1];
        end
    end

    // Edge detect stage: compare synchronised clock with its delayed copy.
    assign edge_pulse = clk_sync[SYNC_STAGES-1] & ~clk_sync_d;
    assign data_bit   = data_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pdm_mic_capture.sv
// PDM microphone receive path: synchronises mic_clk/mic_data, counts ones
// over back-to-back windows of DECIM mic-clock rising edges, and presents
// each count as an unsigned PCM sample on a valid/ready stream.
//   clk, reset : system clock, synchronous active-high reset
//   enable     : capture enable; low returns to IDLE and drops the window
//   mic_clk    : mic clock as driven to the microphone
//   mic_data   : PDM data from the microphone
//   pcm        : PCM sample stream (master side)
//   overrun    : sticky, a completed sample was dropped; cleared by reset or
//                while enable is low
//   busy       : high while accumulating a window
module pdm_mic_capture
    import audio_pkg::*;
#(
    parameter int DECIM       = DECIM_DEFAULT,
    parameter int PCM_W       = PCM_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    mic_clk,
    input  logic                    mic_data,
    pdm_mic_capture_if.master       pcm,
    output logic                    overrun,
    output logic                    busy
);

    // Holds 0..DECIM, so the ones-count can never wrap.
    localparam int ACC_W = clog2(DECIM + 1);
    localparam logic [ACC_W-1:0] LAST_CNT = ACC_W'(DECIM - 1);

    // Zero-extend a window sum to the PCM width.
    function automatic logic [PCM_W-1:0] to_pcm(input logic [ACC_W-1:0] s);
        logic [PCM_W-1:0] r;
        r = '0;
        r[ACC_W-1:0] = s;
        return r;
    endfunction

    logic             edge_pulse;
    logic             data_bit;

    state_t           state;
    state_t           state_n;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_n;
    logic [ACC_W-1:0] bit_cnt;
    logic [ACC_W-1:0] bit_cnt_n;
    logic [ACC_W-1:0] sum;
    logic             complete;

    pdm_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .mic_clk    (mic_clk),
        .mic_data   (mic_data),
        .edge_pulse (edge_pulse),
        .data_bit   (data_bit)
    );

    assign sum  = acc + ACC_W'(data_bit);
    assign busy = (state == ST_ACCUM);

    // Next-state and accumulator update. acc is 0 in IDLE, so the first
    // edge of a window loads sum = bit just like any other edge.
    always_comb begin
        state_n   = state;
        acc_n     = acc;
        bit_cnt_n = bit_cnt;
        complete  = 1'b0;
        if (!enable) begin
            state_n   = ST_IDLE;
            acc_n     = '0;
            bit_cnt_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (edge_pulse) begin
                        state_n   = ST_ACCUM;
                        acc_n     = sum;
                        bit_cnt_n = ACC_W'(1);
                    end
                end
                ST_ACCUM: begin
                    if (edge_pulse) begin
                        if (bit_cnt == LAST_CNT) begin
                            // Final bit of the window; next edge opens a new one.
                            complete  = 1'b1;
                            acc_n     = '0;
                            bit_cnt_n = '0;
                        end else begin
                            acc_n     = sum;
                            bit_cnt_n = bit_cnt + ACC_W'(1);
                        end
                    end
                end
                default: begin
                    state_n   = ST_IDLE;
                    acc_n     = '0;
                    bit_cnt_n = '0;
                end
            endcase
        end
    end

    // Accumulate stage: FSM state, running sum and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            acc     <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            bit_cnt <= bit_cnt_n;
        end
    end

    // Output stage: one-deep sample register with drop-on-full and a
    // sticky overrun flag. A transfer and a new load in the same cycle keep
    // pcm_valid high continuously.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcm.pcm_data  <= '0;
            pcm.pcm_valid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (complete && (!pcm.pcm_valid || pcm.pcm_ready)) begin
                pcm.pcm_data  <= to_pcm(sum);
                pcm.pcm_valid <= 1'b1;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (pcm.pcm_ready) begin
                pcm.pcm_valid <= 1'b0;
            end
            if (!enable) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Scoreboard bench for pdm_mic_capture: directed PDM windows, expected PCM
// counts queued at stimulus time and checked by a handshake monitor.
module tb_pdm_mic_capture;
    import audio_pkg::*;

    localparam int DECIM = 128;
    localparam int PCM_W = 8;
    localparam int SYNC  = 2;
    localparam int HALF  = 20;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic mic_clk;
    logic mic_data;
    logic overrun;
    logic busy;

    pdm_mic_capture_if #(.PCM_W(PCM_W)) pcm ();

    pdm_mic_capture #(
        .DECIM       (DECIM),
        .PCM_W       (PCM_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mic_clk  (mic_clk),
        .mic_data (mic_data),
        .pcm      (pcm),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [PCM_W-1:0] exp_q[$];
    logic [PCM_W-1:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted sample must match the head of the queue.
    always @(negedge clk) begin
        if (pcm.pcm_valid === 1'b1 && pcm.pcm_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sample: got %0d expected none", pcm.pcm_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sample", 32'(pcm.pcm_data), 32'(mon_exp));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic one_bit(input logic b);
        mic_data = b;
        mic_clk  = 1'b1;
        tick(HALF);
        mic_clk  = 1'b0;
        tick(HALF);
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        mic_clk        = 1'b0;
        mic_data       = 1'b0;
        pcm.pcm_ready  = 1'b1;
        tick(3);
        check("reset_valid",   32'(pcm.pcm_valid), 0);
        check("reset_data",    32'(pcm.pcm_data),  0);
        check("reset_overrun", 32'(overrun),       0);
        check("reset_busy",    32'(busy),          0);
        reset  = 1'b0;
        enable = 1'b1;

        // All ones: two back-to-back windows of 128.
        exp_q.push_back(8'd128);
        repeat (DECIM - 1) one_bit(1'b1);
        check("no_early_sample", 32'(pcm.pcm_valid), 0);
        check("busy_accum",      32'(busy),          1);
        one_bit(1'b1);
        exp_q.push_back(8'd128);
        repeat (DECIM) one_bit(1'b1);

        // Alternating 1,0 then all zeros.
        exp_q.push_back(8'd64);
        for (int i = 0; i < DECIM; i++) one_bit((i % 2) == 0);
        exp_q.push_back(8'd0);
        repeat (DECIM) one_bit(1'b0);

        // Ready held low for 2.5 windows.
        pcm.pcm_ready = 1'b0;
        repeat (DECIM) one_bit(1'b1);
        check("hold_valid",   32'(pcm.pcm_valid), 1);
        check("hold_data",    32'(pcm.pcm_data),  128);
        check("hold_overrun", 32'(overrun),       0);
        repeat (DECIM) one_bit(1'b0);
        check("drop_valid",   32'(pcm.pcm_valid), 1);
        check("drop_data",    32'(pcm.pcm_data),  128);
        check("drop_overrun", 32'(overrun),       1);
        repeat (DECIM / 2) one_bit(1'b0);
        exp_q.push_back(8'd128);
        pcm.pcm_ready = 1'b1;
        tick(1);
        check("drained_valid",  32'(pcm.pcm_valid), 0);
        check("overrun_sticky", 32'(overrun),       1);
        exp_q.push_back(8'd0);
        repeat (DECIM / 2) one_bit(1'b0);

        // Enable dropped after edge 50 for 3 mic periods.
        repeat (50) one_bit(1'b1);
        check("pre_disable_overrun", 32'(overrun), 1);
        enable = 1'b0;
        repeat (3) one_bit(1'b1);
        check("disabled_overrun", 32'(overrun),       0);
        check("disabled_busy",    32'(busy),          0);
        check("disabled_valid",   32'(pcm.pcm_valid), 0);
        enable = 1'b1;
        exp_q.push_back(8'd100);
        for (int i = 0; i < DECIM; i++) one_bit(i < 100);

        // Reset pulse just after edge 90 of a window.
        repeat (89) one_bit(1'b1);
        mic_data = 1'b1;
        mic_clk  = 1'b1;
        tick(HALF);
        mic_clk  = 1'b0;
        tick(2);
        check("pre_reset_data", 32'(pcm.pcm_data), 100);
        check("pre_reset_busy", 32'(busy),         1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midreset_data",    32'(pcm.pcm_data),  0);
        check("midreset_valid",   32'(pcm.pcm_valid), 0);
        check("midreset_overrun", 32'(overrun),       0);
        check("midreset_busy",    32'(busy),          0);
        tick(HALF - 3);
        exp_q.push_back(8'd32);
        for (int i = 0; i < DECIM; i++) one_bit(i < 32);

        // Ready rises exactly on the completion cycle of a pending sample.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        pcm.pcm_ready = 1'b0;
        exp_q.push_back(8'd10);
        for (int i = 0; i < DECIM; i++) one_bit(i < 10);
        check("pending_valid", 32'(pcm.pcm_valid), 1);
        check("pending_data",  32'(pcm.pcm_data),  10);
        exp_q.push_back(8'd20);
        for (int i = 0; i < DECIM - 1; i++) one_bit(i < 20);
        mic_data = 1'b0;
        mic_clk  = 1'b1;
        tick(2);
        pcm.pcm_ready = 1'b1;
        check("swap_old_valid", 32'(pcm.pcm_valid), 1);
        check("swap_old_data",  32'(pcm.pcm_data),  10);
        tick(1);
        check("swap_valid_continuous", 32'(pcm.pcm_valid), 1);
        check("swap_new_data",         32'(pcm.pcm_data),  20);
        check("swap_overrun",          32'(overrun),       0);
        tick(1);
        check("swap_consumed", 32'(pcm.pcm_valid), 0);
        tick(HALF - 4);
        mic_clk = 1'b0;
        tick(HALF);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
